// File: rtl/npp_pkg.sv
// rtl/npp_pkg.sv - shared types and sizes for the NPP flit transmitter
package npp_pkg;

    localparam int NPP_FLIT_W      = 182;
    localparam int NPP_NUM_VC      = 8;
    localparam int NPP_MAX_CREDITS = 8;
    localparam int NPP_VC_W        = $clog2(NPP_NUM_VC);

    typedef logic [NPP_FLIT_W-1:0] npp_flit_t;
    typedef logic [NPP_VC_W-1:0]   npp_vc_t;

    typedef enum logic {
        IDLE,
        ACTIVE
    } npp_tx_state_t;

endpackage

// File: rtl/npp_credit_counter.sv
// rtl/npp_credit_counter.sv - saturating per-VC credit counter with overflow event
module npp_credit_counter
    import npp_pkg::*;
#(
    parameter int  MAX_CREDITS = NPP_MAX_CREDITS,
    localparam int CNT_W       = $clog2(MAX_CREDITS + 1)
) (
    input  logic             aclk,
    input  logic             areset,
    input  logic             inc,
    input  logic             dec,
    input  logic             clr,
    output logic [CNT_W-1:0] count,
    output logic             nonzero,
    output logic             ovf
);

    logic at_max;

    assign at_max  = (count == CNT_W'(MAX_CREDITS));
    assign nonzero = (count != '0);
    // A return on a full counter is only an error when no send frees a slot
    assign ovf     = inc && !dec && at_max;

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && !dec && !at_max) begin
            count <= count + CNT_W'(1);
        end else if (dec && !inc) begin
            count <= count - CNT_W'(1);
        end
    end

endmodule

// File: rtl/npp_flit_tx.sv
// rtl/npp_flit_tx.sv - credit-managed flit transmitter into one NPP ingress port
module npp_flit_tx
    import npp_pkg::*;
#(
    parameter int  FLIT_W      = NPP_FLIT_W,
    parameter int  NUM_VC      = NPP_NUM_VC,
    parameter int  MAX_CREDITS = NPP_MAX_CREDITS,
    localparam int VC_W        = $clog2(NUM_VC),
    localparam int CNT_W       = $clog2(MAX_CREDITS + 1)
) (
    input  logic                    aclk,
    input  logic                    areset,
    input  logic [FLIT_W-1:0]       s_flit,
    input  logic [VC_W-1:0]         s_vc,
    input  logic                    s_valid,
    output logic                    s_ready,
    output logic [FLIT_W-1:0]       npp_flit,
    output logic [NUM_VC-1:0]       npp_valid,
    input  logic [NUM_VC-1:0]       npp_credit_return,
    input  logic                    npp_credit_rdy,
    output logic                    credit_ovf,
    output logic [NUM_VC*CNT_W-1:0] credit_cnt
);

    npp_tx_state_t state_q, state_d;
    logic          link_up;
    logic          cnt_clr;
    logic          accept;
    logic [NUM_VC-1:0] vc_nonzero;
    logic [NUM_VC-1:0] vc_ovf;

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        link_up = 1'b0;
        cnt_clr = 1'b0;
        case (state_q)
            IDLE: begin
                if (npp_credit_rdy) begin
                    state_d = ACTIVE;
                end
            end
            ACTIVE: begin
                link_up = 1'b1;
                // Link loss forfeits every outstanding credit
                if (!npp_credit_rdy) begin
                    state_d = IDLE;
                    cnt_clr = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign s_ready = link_up && vc_nonzero[s_vc];
    assign accept  = s_valid && s_ready;

    for (genvar v = 0; v < NUM_VC; v++) begin : g_vc
        logic [CNT_W-1:0] count;

        npp_credit_counter #(
            .MAX_CREDITS (MAX_CREDITS)
        ) u_cnt (
            .aclk    (aclk),
            .areset  (areset),
            .inc     (link_up && npp_credit_return[v]),
            .dec     (accept && (s_vc == VC_W'(v))),
            .clr     (cnt_clr),
            .count   (count),
            .nonzero (vc_nonzero[v]),
            .ovf     (vc_ovf[v])
        );

        assign credit_cnt[v*CNT_W +: CNT_W] = count;
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            credit_ovf <= 1'b0;
        end else if (|vc_ovf) begin
            credit_ovf <= 1'b1;
        end
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            npp_flit  <= '0;
            npp_valid <= '0;
        end else begin
            npp_valid <= '0;
            if (accept) begin
                npp_flit  <= s_flit;
                npp_valid <= NUM_VC'(1) << s_vc;
            end
        end
    end

endmodule

// File: tb/tb_npp_flit_tx.sv
// tb/tb_npp_flit_tx.sv - scoreboard bench for npp_flit_tx
module tb_npp_flit_tx;
    import npp_pkg::*;

    localparam int FW = 182;
    localparam int NV = 8;
    localparam int MC = 8;
    localparam int VW = 3;
    localparam int CW = 4;

    logic              aclk = 1'b0;
    logic              areset;
    logic [FW-1:0]     s_flit;
    logic [VW-1:0]     s_vc;
    logic              s_valid;
    logic              s_ready;
    logic [FW-1:0]     npp_flit;
    logic [NV-1:0]     npp_valid;
    logic [NV-1:0]     npp_credit_return;
    logic              npp_credit_rdy;
    logic              credit_ovf;
    logic [NV*CW-1:0]  credit_cnt;

    npp_flit_tx dut (
        .aclk              (aclk),
        .areset            (areset),
        .s_flit            (s_flit),
        .s_vc              (s_vc),
        .s_valid           (s_valid),
        .s_ready           (s_ready),
        .npp_flit          (npp_flit),
        .npp_valid         (npp_valid),
        .npp_credit_return (npp_credit_return),
        .npp_credit_rdy    (npp_credit_rdy),
        .credit_ovf        (credit_ovf),
        .credit_cnt        (credit_cnt)
    );

    always #5 aclk = ~aclk;

    typedef struct {
        logic [VW-1:0] vc;
        logic [FW-1:0] flit;
    } exp_t;

    exp_t          sb[$];
    int            n_vec = 0;
    int            n_err = 0;
    int            cnt_m[NV];
    bit            active_m;
    bit            ovf_m;
    logic [FW-1:0] last_flit_m;

    task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [FW-1:0] rnd();
        logic [191:0] t;
        t = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
        return t[FW-1:0];
    endfunction

    function automatic int cnt_of(input int v);
        return int'(credit_cnt[v*CW +: CW]);
    endfunction

    // Reference model: link state, credits and expected output stream
    always @(posedge aclk or posedge areset) begin
        if (areset) begin
            for (int v = 0; v < NV; v++) cnt_m[v] = 0;
            active_m    = 1'b0;
            ovf_m       = 1'b0;
            last_flit_m = '0;
            sb.delete();
        end else if (!active_m) begin
            if (npp_credit_rdy) active_m = 1'b1;
        end else begin
            bit   acc;
            exp_t e;
            acc = s_valid && (cnt_m[s_vc] != 0);
            if (acc) begin
                e.vc   = s_vc;
                e.flit = s_flit;
                sb.push_back(e);
            end
            for (int v = 0; v < NV; v++) begin
                bit dec, inc;
                dec = acc && (int'(s_vc) == v);
                inc = npp_credit_return[v];
                if (!npp_credit_rdy) cnt_m[v] = 0;
                else if (inc && !dec) begin
                    if (cnt_m[v] == MC) ovf_m = 1'b1;
                    else cnt_m[v]++;
                end else if (dec && !inc) cnt_m[v]--;
            end
            if (!npp_credit_rdy) active_m = 1'b0;
        end
    end

    always @(negedge aclk) begin
        logic [NV*CW-1:0] pk;
        exp_t e;
        for (int v = 0; v < NV; v++) pk[v*CW +: CW] = CW'(cnt_m[v]);
        chk("s_ready", s_ready, active_m && (cnt_m[s_vc] != 0));
        chk("credit_cnt", credit_cnt, pk);
        chk("credit_ovf", credit_ovf, ovf_m);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            last_flit_m = e.flit;
            chk("npp_valid", npp_valid, 256'(1) << e.vc);
            chk("npp_flit", npp_flit, e.flit);
        end else begin
            chk("npp_valid_idle", npp_valid, 0);
            chk("npp_flit_hold", npp_flit, last_flit_m);
        end
    end

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    initial begin
        logic [FW-1:0] f;
        areset = 1'b1;
        s_valid = 1'b0;
        s_vc = '0;
        s_flit = '0;
        npp_credit_return = '0;
        npp_credit_rdy = 1'b0;
        repeat (2) @(posedge aclk);
        #1;
        chk("rst_valid", npp_valid, 0);
        chk("rst_flit", npp_flit, 0);
        chk("rst_ready", s_ready, 0);
        chk("rst_ovf", credit_ovf, 0);
        chk("rst_cnt", credit_cnt, 0);
        areset = 1'b0;

        // Init: 4 credits on VC0, 5 flits offered
        npp_credit_rdy = 1'b1;
        tick();
        npp_credit_return = 8'h01;
        repeat (4) tick();
        npp_credit_return = '0;
        chk("init_cnt0", cnt_of(0), 4);
        s_vc = 0;
        s_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            s_flit = rnd();
            #1;
            chk("init_ready", s_ready, (i < 4) ? 1 : 0);
            tick();
        end
        s_valid = 1'b0;

        // Simultaneous send and return on VC3
        npp_credit_return = 8'h08;
        tick();
        s_vc = 3;
        s_valid = 1'b1;
        s_flit = rnd();
        #1;
        chk("simul_ready", s_ready, 1);
        tick();
        s_valid = 1'b0;
        npp_credit_return = '0;
        chk("simul_cnt3", cnt_of(3), 1);
        chk("simul_valid", npp_valid, 8'h08);

        // Overflow on VC7
        npp_credit_return = 8'h80;
        repeat (9) tick();
        npp_credit_return = '0;
        chk("ovf_cnt7", cnt_of(7), 8);
        chk("ovf_flag", credit_ovf, 1);
        repeat (2) tick();
        chk("ovf_held", credit_ovf, 1);

        // Interleave VC1/VC2
        npp_credit_return = 8'h06;
        repeat (2) tick();
        npp_credit_return = '0;
        s_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            s_vc = (i % 2 == 1) ? 3'd2 : 3'd1;
            s_flit = rnd();
            tick();
            chk("ilv_valid", npp_valid, (i % 2 == 1) ? 8'h04 : 8'h02);
        end
        s_vc = 1;
        #1;
        chk("ilv_ready_vc1", s_ready, 0);
        s_vc = 2;
        #1;
        chk("ilv_ready_vc2", s_ready, 0);
        s_valid = 1'b0;

        // Link drop during a VC4 stream
        npp_credit_return = 8'h10;
        repeat (3) tick();
        npp_credit_return = '0;
        s_vc = 4;
        s_valid = 1'b1;
        s_flit = rnd();
        tick();
        f = rnd();
        s_flit = f;
        npp_credit_rdy = 1'b0;
        tick();
        chk("drop_valid", npp_valid, 8'h10);
        chk("drop_flit", npp_flit, f);
        chk("drop_ready", s_ready, 0);
        chk("drop_cnt", credit_cnt, 0);
        s_valid = 1'b0;
        tick();
        npp_credit_rdy = 1'b1;
        tick();
        npp_credit_return = 8'h10;
        tick();
        npp_credit_return = '0;
        chk("restart_cnt4", cnt_of(4), 1);

        // Async reset with a flit in the output register
        s_vc = 4;
        s_valid = 1'b1;
        s_flit = rnd();
        tick();
        s_valid = 1'b0;
        areset = 1'b1;
        #1;
        chk("arst_valid", npp_valid, 0);
        chk("arst_flit", npp_flit, 0);
        chk("arst_ready", s_ready, 0);
        chk("arst_ovf", credit_ovf, 0);
        chk("arst_cnt", credit_cnt, 0);
        tick();
        areset = 1'b0;
        tick();
        repeat (3) tick();
        chk("sb_empty", sb.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
